// File: rtl/fp_add_normalizer_if.sv
// fp_add_normalizer_if: handshake and data bundle for the FP post-adder normalizer.
//   Upstream side : in_valid/in_ready with the raw mantissa, carry-out, exponent and sign.
//   Downstream side: out_valid/out_ready with the normalized fraction, exponent, sign and
//                   zero/overflow flags.
//   modport master : the producer/consumer around the block (drives inputs, sees results).
//   modport slave  : the normalizer itself.
interface fp_add_normalizer_if #(
  parameter int MANT_W = 53,
  parameter int EXP_W  = 11
) ();
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic              cout_in;
  logic [EXP_W-1:0]  exp_in;
  logic              sign_in;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-2:0] frac_out;
  logic [EXP_W-1:0]  exp_out;
  logic              sign_out;
  logic              zero_out;
  logic              ovf_out;

  modport master (
    output in_valid, mant_in, cout_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, frac_out, exp_out, sign_out, zero_out, ovf_out
  );

  modport slave (
    input  in_valid, mant_in, cout_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, frac_out, exp_out, sign_out, zero_out, ovf_out
  );
endinterface

// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer: sequential normalizer placed after the mantissa add/sub stage.
// Takes the raw 53-bit mantissa, its carry-out, the larger operand's exponent and the
// sign, and produces an IEEE-754 double (sign, 11-bit exponent, 52-bit fraction) by
// shifting one bit per clock. Truncates on the right shift (round toward zero).
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; aborts any in-flight result
//   bus  - fp_add_normalizer_if.slave: in_valid/in_ready + operands,
//          out_valid/out_ready + frac_out/exp_out/sign_out/zero_out/ovf_out
module fp_add_normalizer #(
  parameter int MANT_W  = 53,
  parameter int EXP_W   = 11,
  parameter int EXP_MAX = 2047
) (
  input  logic                clk,
  input  logic                rst,
  fp_add_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RSHIFT = 2'd1,
    LSHIFT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int               FRAC_W   = MANT_W - 1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ALL  = EXP_W'(EXP_MAX);
  localparam logic [EXP_W:0]   EXP_LIM  = (EXP_W + 1)'(EXP_MAX);

  state_t              state_r, state_s;
  // loaded_r marks the decision cycle that follows a capture while still in IDLE
  logic                loaded_r, loaded_s;
  logic [MANT_W:0]     m_r, m_s;
  logic [EXP_W-1:0]    e_r, e_s;
  logic                sign_r, sign_s;

  logic                in_ready_r, in_ready_s;
  logic                out_valid_r, out_valid_s;
  logic [FRAC_W-1:0]   frac_r, frac_s;
  logic [EXP_W-1:0]    exp_r, exp_s;
  logic                sign_out_r, sign_out_s;
  logic                zero_r, zero_s;
  logic                ovf_r, ovf_s;

  logic                done_s;
  logic [FRAC_W-1:0]   done_frac_s;
  logic [EXP_W-1:0]    done_exp_s;
  logic                done_zero_s;
  logic                done_ovf_s;

  logic [MANT_W-1:0]   m_shl_s;
  logic [EXP_W:0]      e_inc_s;
  logic [EXP_W-1:0]    e_dec_s;

  assign m_shl_s = m_r[MANT_W-1:0] << 1;
  assign e_inc_s = (EXP_W + 1)'(e_r) + (EXP_W + 1)'(1);
  assign e_dec_s = e_r - EXP_ONE;

  // Next-state and next-output computation for the normalizer FSM
  always_comb begin
    state_s     = state_r;
    loaded_s    = loaded_r;
    m_s         = m_r;
    e_s         = e_r;
    sign_s      = sign_r;
    out_valid_s = out_valid_r;
    frac_s      = frac_r;
    exp_s       = exp_r;
    sign_out_s  = sign_out_r;
    zero_s      = zero_r;
    ovf_s       = ovf_r;
    done_s      = 1'b0;
    done_frac_s = m_r[FRAC_W-1:0];
    done_exp_s  = e_r;
    done_zero_s = 1'b0;
    done_ovf_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (loaded_r) begin
          loaded_s = 1'b0;
          if (m_r[MANT_W]) begin
            state_s = RSHIFT;
          end else if (m_r[MANT_W-1:0] == '0) begin
            done_s      = 1'b1;
            done_zero_s = 1'b1;
            done_exp_s  = '0;
            done_frac_s = '0;
          end else if (m_r[MANT_W-1]) begin
            // A subnormal sum that reached the hidden bit becomes exponent 1
            done_s     = 1'b1;
            done_exp_s = (e_r == '0) ? EXP_ONE : e_r;
          end else if (e_r == '0) begin
            done_s     = 1'b1;
            done_exp_s = '0;
          end else begin
            state_s = LSHIFT;
          end
        end else if (bus.in_valid && in_ready_r) begin
          loaded_s = 1'b1;
          m_s      = {bus.cout_in, bus.mant_in};
          e_s      = bus.exp_in;
          sign_s   = bus.sign_in;
        end else begin
          loaded_s = 1'b0;
        end
      end

      RSHIFT: begin
        m_s    = m_r >> 1;
        e_s    = e_inc_s[EXP_W-1:0];
        done_s = 1'b1;
        if (e_inc_s >= EXP_LIM) begin
          done_ovf_s  = 1'b1;
          done_exp_s  = EXP_ALL;
          done_frac_s = '0;
        end else begin
          done_exp_s  = e_inc_s[EXP_W-1:0];
          done_frac_s = m_r[MANT_W-1:1];
        end
      end

      LSHIFT: begin
        if (e_r <= EXP_ONE) begin
          done_s     = 1'b1;
          done_exp_s = '0;
        end else begin
          // Shift and test the shifted value in the same cycle so the exit costs no extra clock
          m_s         = {1'b0, m_shl_s};
          e_s         = e_dec_s;
          done_frac_s = m_shl_s[FRAC_W-1:0];
          if (m_shl_s[MANT_W-1]) begin
            done_s     = 1'b1;
            done_exp_s = e_dec_s;
          end else if (e_dec_s <= EXP_ONE) begin
            done_s     = 1'b1;
            done_exp_s = '0;
          end else begin
            done_s = 1'b0;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_s = 1'b0;
          zero_s      = 1'b0;
          ovf_s       = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = DONE;
        end
      end

      default: begin
        state_s  = IDLE;
        loaded_s = 1'b0;
      end
    endcase

    if (done_s) begin
      state_s     = DONE;
      out_valid_s = 1'b1;
      frac_s      = done_frac_s;
      exp_s       = done_exp_s;
      sign_out_s  = sign_r;
      zero_s      = done_zero_s;
      ovf_s       = done_ovf_s;
    end else begin
      out_valid_s = out_valid_s;
    end

    in_ready_s = (state_s == IDLE) && !loaded_s;
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      loaded_r    <= 1'b0;
      m_r         <= '0;
      e_r         <= '0;
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      frac_r      <= '0;
      exp_r       <= '0;
      sign_out_r  <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      loaded_r    <= loaded_s;
      m_r         <= m_s;
      e_r         <= e_s;
      sign_r      <= sign_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      frac_r      <= frac_s;
      exp_r       <= exp_s;
      sign_out_r  <= sign_out_s;
      zero_r      <= zero_s;
      ovf_r       <= ovf_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.frac_out  = frac_r;
  assign bus.exp_out   = exp_r;
  assign bus.sign_out  = sign_out_r;
  assign bus.zero_out  = zero_r;
  assign bus.ovf_out   = ovf_r;

endmodule

// File: doc/fp_add_normalizer.md
Name: fp_add_normalizer

Overview:
- Sequential post-adder normalizer for the FP adder datapath. Consumes the raw 53-bit mantissa result, its carry-out, the 11-bit exponent and the sign from the mantissa add/sub stage.
- Produces a normalized IEEE-754 double: sign, 11-bit exponent and 52-bit fraction.
- Shifts one bit per cycle under a valid/ready handshake on both sides, trading latency for area.

Parameters:
- MANT_W, 53, mantissa width including hidden bit
- EXP_W, 11, exponent width
- EXP_MAX, 2047, all-ones exponent (Inf/NaN encoding)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result valid
- in_ready  output  1  block can accept a result
- mant_in  input  53  raw mantissa sum/difference from the add/sub stage
- cout_in  input  1  carry-out of the mantissa add (1 = sum overflowed bit 52)
- exp_in  input  11  exponent of the larger operand
- sign_in  input  1  result sign
- out_valid  output  1  normalized result valid
- out_ready  input  1  downstream accepts result
- frac_out  output  52  normalized fraction (hidden bit dropped)
- exp_out  output  11  normalized exponent
- sign_out  output  1  result sign
- zero_out  output  1  result is exactly zero
- ovf_out  output  1  exponent overflowed; result forced to Inf

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - frac_out=0, exp_out=0, sign_out=0, zero_out=0, ovf_out=0.
  - Reset mid-operation aborts the in-flight result; nothing is emitted.
- States: IDLE, RSHIFT, LSHIFT, DONE.
- in_ready=1 only in IDLE. A transfer occurs when in_valid & in_ready at an edge: capture {cout_in, mant_in, exp_in, sign_in} into internal registers M[53:0] and E[10:0].
- Transition from IDLE, evaluated on the captured values in the cycle after capture:
  - cout_in=1 -> RSHIFT.
  - mant_in==0 and cout_in=0 -> DONE with zero_out=1, exp_out=0, frac_out=0, sign_out=sign_in.
  - mant_in[52]=1 -> DONE directly. If exp_in==0, exp_out=1 (a subnormal sum carried into the normal range).
  - Otherwise -> LSHIFT.
- RSHIFT, exactly 1 cycle:
  - M = M>>1; the dropped LSB is discarded (truncation, round toward zero). E = E+1.
  - If E+1 == EXP_MAX: ovf_out=1, exp_out=EXP_MAX, frac_out=0.
  - Always -> DONE.
- LSHIFT, once per cycle:
  - If M[52]=1 -> DONE.
  - Else if E<=1 -> DONE with exp_out=0 (subnormal result; M is kept unshifted at this point).
  - Else M = M<<1, E = E-1, and stay in LSHIFT.
  - If exp_in==0 on entry, go to DONE immediately with exp_out=0 (subnormal passthrough).
  - Maximum 52 shift cycles.
- DONE:
  - out_valid=1; outputs are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0, zero_out/ovf_out cleared, -> IDLE.
  - Data outputs keep their last values after the handshake.
- Latency from the input transfer edge to out_valid:
  - 1 cycle: zero result or already normalized.
  - 2 cycles: carry-out case.
  - 1+k cycles: k-bit left shift.
- frac_out = M[51:0] at DONE entry.
- Input is never accepted in the same cycle as an output handshake; the next input is accepted in IDLE one cycle later.
- Zero detection: a zero result is not signed-fixed; sign is passed through as given.

Test Plan:
- Carry case: mant_in=53'h1F_FFFF_FFFF_FFFF, cout_in=1, exp_in=1023, sign_in=0 -> after 2 cycles out_valid=1, exp_out=1024, frac_out=52'hF_FFFF_FFFF_FFFF.
- Normalized passthrough: mant_in=53'h10_0000_0000_0001, cout_in=0, exp_in=1000 -> 1 cycle, exp_out=1000, frac_out=52'h0_0000_0000_0001.
- Cancellation: mant_in=53'h1 (only bit 0), exp_in=1023 -> 52 LSHIFT cycles, exp_out=971, frac_out=0.
- Subnormal underflow: mant_in=53'h0_0000_0000_0100, exp_in=3 -> stops at E=1 with exp_out=0; out_valid after 3 cycles.
- Zero and overflow: mant_in=0 -> zero_out=1, exp_out=0. mant_in=53'h10_0000_0000_0000, cout_in=1, exp_in=2046 -> ovf_out=1, exp_out=2047, frac_out=0.
- Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Assert rst during LSHIFT -> next cycle out_valid=0, in_ready=1, all outputs 0.
